bist_adder_nbit: RTL

- Self-contained BIST engine for a parametrised N-bit ripple-carry adder. Next generation of the team's 1-bit full-adder CUT with fault injection.
- An LFSR pattern generator drives the faultable CUT and a fault-free golden adder in parallel. Two MISRs compact the responses. A per-pattern comparator counts mismatches.
- On completion the block reports pass/fail, the CUT signature, the fail count and the first failing pattern index.

---
 rtl/bist_adder_nbit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bist_adder_nbit.sv
// BIST engine for an N-bit ripple-carry adder: LFSR patterns drive a faultable CUT and a
// golden adder side by side; two MISRs compact the responses and a comparator counts misses.
module bist_adder_nbit #(
  parameter int               WIDTH        = 4,
  parameter int               NUM_PATTERNS = 511,
  parameter logic [2*WIDTH:0] LFSR_TAPS    = 9'h110,
  parameter logic [2*WIDTH:0] LFSR_SEED    = 9'h001,
  parameter logic [WIDTH:0]   MISR_TAPS    = 5'h14,
  localparam int L   = 2*WIDTH + 1,
  localparam int M   = WIDTH + 1,
  localparam int C   = $clog2(NUM_PATTERNS + 1),
  localparam int FBW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           fault_en,
  input  logic [1:0]     fault_sel,
  input  logic [FBW-1:0] fault_bit,
  input  logic           fault_val,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [M-1:0]   signature,
  output logic [C-1:0]   fail_count,
  output logic [C-1:0]   first_fail_idx
);

  typedef enum logic [1:0] {IDLE, RUN, EVAL, DONE} state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [L-1:0] SEED_EFF = (LFSR_SEED == '0) ? L'(1) : LFSR_SEED;
  localparam logic [C-1:0] LAST_IDX = C'(NUM_PATTERNS - 1);

  state_t         state;
  logic [L-1:0]   lfsr;
  logic [M-1:0]   cut_misr;
  logic [M-1:0]   gold_misr;
  logic [C-1:0]   pidx;

  logic           f_en;
  logic [1:0]     f_sel;
  logic [FBW-1:0] f_bit;
  logic           f_val;

  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             cin_p0;
  logic [WIDTH-1:0] hit_p0;
  logic [M-1:0]     cut_resp_p0;
  logic [M-1:0]     gold_resp_p0;
  logic             vld_p0;
  logic             miscompare_p0;

  function automatic logic [L-1:0] lfsr_step(input logic [L-1:0] s);
    return {s[L-2:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [M-1:0] misr_step(input logic [M-1:0] s, input logic [M-1:0] r);
    return {s[M-2:0], ^(s & MISR_TAPS)} ^ r;
  endfunction

  function automatic logic [C-1:0] sat_inc(input logic [C-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

  // Stage p0: pattern decode, CUT and golden responses, compare
  assign a_p0         = lfsr[WIDTH:1];
  assign b_p0         = lfsr[2*WIDTH:WIDTH+1];
  assign cin_p0       = lfsr[0];
  assign gold_resp_p0 = M'(a_p0) + M'(b_p0) + M'(cin_p0);
  assign vld_p0       = (state == RUN);

  always_comb begin
    hit_p0 = '0;
    for (int k = 0; k < WIDTH; k++) begin
      hit_p0[k] = f_en && (int'(f_bit) == k);
    end
  end

  // A forced a-bit or carry feeds the downstream carry chain; a forced sum bit does not.
  always_comb begin : cut_adder
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic             ak;
    logic             ck;
    c    = '0;
    s    = '0;
    ak   = 1'b0;
    ck   = 1'b0;
    c[0] = cin_p0;
    for (int k = 0; k < WIDTH; k++) begin
      ak       = (hit_p0[k] && f_sel == 2'd0) ? f_val : a_p0[k];
      ck       = (hit_p0[k] && f_sel == 2'd1) ? f_val : c[k];
      s[k]     = (hit_p0[k] && f_sel == 2'd2) ? f_val : (ak ^ b_p0[k] ^ ck);
      c[k+1]   = (ak & b_p0[k]) | (ak & ck) | (b_p0[k] & ck);
    end
    cut_resp_p0 = {(f_en && f_sel == 2'd3) ? f_val : c[WIDTH], s};
  end

  assign miscompare_p0 = vld_p0 && (cut_resp_p0 != gold_resp_p0);

  // Stage p1: control FSM, LFSR/MISR state and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      lfsr           <= '0;
      cut_misr       <= '0;
      gold_misr      <= '0;
      pidx           <= '0;
      f_en           <= 1'b0;
      f_sel          <= 2'd0;
      f_bit          <= '0;
      f_val          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      signature      <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            lfsr           <= SEED_EFF;
            cut_misr       <= '0;
            gold_misr      <= '0;
            pidx           <= '0;
            f_en           <= fault_en;
            f_sel          <= fault_sel;
            f_bit          <= fault_bit;
            f_val          <= fault_val;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            signature      <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            state          <= RUN;
          end else if (state == DONE) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        RUN: begin
          lfsr      <= lfsr_step(lfsr);
          cut_misr  <= misr_step(cut_misr, cut_resp_p0);
          gold_misr <= misr_step(gold_misr, gold_resp_p0);
          if (miscompare_p0) begin
            fail_count <= sat_inc(fail_count);
            if (fail_count == '0) first_fail_idx <= pidx;
          end
          pidx <= pidx + 1'b1;
          if (pidx == LAST_IDX) state <= EVAL;
        end
        EVAL: begin
          pass      <= (cut_misr == gold_misr);
          signature <= cut_misr;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
